// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and constants for the keypad digit capture.
// Holds the FSM state enum, the 4x4 key map and one-hot-low helpers.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        HELD,
        RELEASE
    } state_t;

    // One-hot-low pattern for index 0..3; used both for
    // column drive and for the latched row pattern.
    localparam logic [3:0] ONE_LOW [4] = '{
        4'b1110, 4'b1101, 4'b1011, 4'b0111
    };

    // KEY_MAP[row][col]
    localparam logic [3:0] KEY_MAP [4][4] = '{
        '{4'h1, 4'h2, 4'h3, 4'hA},
        '{4'h4, 4'h5, 4'h6, 4'hB},
        '{4'h7, 4'h8, 4'h9, 4'hC},
        '{4'hE, 4'h0, 4'hF, 4'hD}
    };

    function automatic logic single_low(input logic [3:0] v);
        logic [2:0] n;
        n = '0;
        for (int i = 0; i < 4; i++) begin
            n = n + {2'b00, ~v[i]};
        end
        return n == 3'd1;
    endfunction

    function automatic logic [1:0] low_index(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (!v[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_digit_capture_if.sv
// keypad_digit_capture_if: keypad pins plus the captured digit outputs.
// rows in (active-low), cols out, left/right digits, new_key pulse.
interface keypad_digit_capture_if;

    logic [3:0] rows;
    logic [3:0] cols;
    logic [3:0] left;
    logic [3:0] right;
    logic       new_key;

    modport master (
        input  rows,
        output cols,
        output left,
        output right,
        output new_key
    );

    modport slave (
        output rows,
        input  cols,
        input  left,
        input  right,
        input  new_key
    );

endinterface

// File: rtl/keypad_digit_capture_row_synchronizer.sv
// row_synchronizer: 2-flop synchronizer for the asynchronous row inputs.
// Ports: clk, reset (async, high), rows in, rows_s out; resets to 1111.
module row_synchronizer (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rows,
    output logic [3:0] rows_s
);

    logic [3:0] meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta   <= 4'hF;
            rows_s <= 4'hF;
        end else begin
            meta   <= rows;
            rows_s <= meta;
        end
    end

endmodule

// File: rtl/keypad_digit_capture.sv
// keypad_digit_capture: scans a 4x4 keypad, debounces and shifts digits.
// Ports: clk, reset (async, high), kp (rows in; cols, left, right, new_key out).
module keypad_digit_capture
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV        = 48000,
    parameter int DEBOUNCE_CYCLES = 960000
) (
    input logic                    clk,
    input logic                    reset,
    keypad_digit_capture_if.master kp
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int BW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] DEB_LAST   = BW'(DEBOUNCE_CYCLES - 1);

    state_t        state_q, state_d;
    logic [DW-1:0] dwell_q;
    logic [BW-1:0] deb_q;
    logic [1:0]    col_q, row_q;
    logic [3:0]    rows_s, left_q, right_q;
    logic          new_key_q;

    logic sample, single, match, idle;
    logic fire, rel_done, advance, counting;

    row_synchronizer u_sync (
        .clk    (clk),
        .reset  (reset),
        .rows   (kp.rows),
        .rows_s (rows_s)
    );

    assign single   = single_low(rows_s);
    assign match    = rows_s == ONE_LOW[row_q];
    assign idle     = rows_s == 4'hF;
    assign sample   = state_q == SCAN && dwell_q == DWELL_LAST;
    assign fire     = state_q == DEBOUNCE && match && deb_q == DEB_LAST;
    assign rel_done = state_q == RELEASE && idle && deb_q == DEB_LAST;
    // Column moves on: a failed sample, a broken debounce, or a
    // fully debounced release. It is frozen otherwise.
    assign advance  = (sample && !single)
                    || (state_q == DEBOUNCE && !match)
                    || rel_done;
    assign counting = (state_q == DEBOUNCE && match)
                    || (state_q == RELEASE && idle);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= SCAN;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            SCAN: begin
                if (sample && single) state_d = DEBOUNCE;
            end
            DEBOUNCE: begin
                if (!match)    state_d = SCAN;
                else if (fire) state_d = HELD;
            end
            HELD: begin
                if (idle) state_d = RELEASE;
            end
            RELEASE: begin
                if (!idle)         state_d = HELD;
                else if (rel_done) state_d = SCAN;
            end
        endcase
    end

    always_comb begin
        kp.cols    = ONE_LOW[col_q];
        kp.left    = left_q;
        kp.right   = right_q;
        kp.new_key = new_key_q;
    end

    // Counters clear on every state change so each state starts
    // its own count from zero; the debounce counter saturates.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dwell_q   <= '0;
            deb_q     <= '0;
            col_q     <= '0;
            row_q     <= '0;
            left_q    <= '0;
            right_q   <= '0;
            new_key_q <= 1'b0;
        end else begin
            new_key_q <= fire;
            if (state_d != state_q || sample) begin
                dwell_q <= '0;
            end else if (state_q == SCAN) begin
                dwell_q <= dwell_q + DW'(1);
            end
            if (state_d != state_q) begin
                deb_q <= '0;
            end else if (counting && deb_q != DEB_LAST) begin
                deb_q <= deb_q + BW'(1);
            end
            if (advance) col_q <= col_q + 2'd1;
            if (sample && single) row_q <= low_index(rows_s);
            if (fire) begin
                left_q  <= right_q;
                right_q <= KEY_MAP[row_q][col_q];
            end
        end
    end

endmodule

// File: tb/tb_keypad_digit_capture.sv
// tb_keypad_digit_capture: directed bench with a behavioural keypad model.
// Drives a simulated key matrix and checks every output each cycle.
module tb_keypad_digit_capture;

    localparam int SD = 4;
    localparam int DB = 8;

    localparam logic [3:0] KM [16] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'hE, 4'h0, 4'hF, 4'hD
    };

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [15:0] down = '0;
    logic [3:0] rows_drv;

    int checks = 0;
    int passes = 0;
    int pulses = 0;
    bit cmp_on = 1'b0;

    keypad_digit_capture_if kp ();

    keypad_digit_capture #(
        .SCAN_DIV        (SD),
        .DEBOUNCE_CYCLES (DB)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .kp    (kp)
    );

    initial forever #5 clk = ~clk;

    // Physical matrix: a held key pulls its row low only while
    // its column is driven low.
    always_comb begin
        rows_drv = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (down[r*4+c] && !kp.cols[c]) rows_drv[r] = 1'b0;
            end
        end
    end
    assign kp.rows = rows_drv;

    function automatic logic [3:0] low_pat(input int i);
        logic [3:0] p;
        p = 4'hF;
        p[i] = 1'b0;
        return p;
    endfunction

    task automatic check(input string name, input logic [7:0] act,
                         input logic [7:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h at %0t",
                      name, act, exp, $time);
    endtask

    // Behavioural model: mode 0 scanning, 1 confirming a press,
    // 2 key down, 3 confirming release. m_run counts stable cycles.
    logic [3:0] m_s1 = 4'hF, m_s2 = 4'hF;
    logic [3:0] m_left = '0, m_right = '0;
    int m_mode = 0, m_col = 0, m_dwell = 0, m_run = 0, m_row = 0;
    bit m_pulse = 1'b0;

    initial forever begin
        @(posedge clk or posedge reset);
        if (reset) begin
            m_s1 = 4'hF; m_s2 = 4'hF;
            m_left = '0; m_right = '0; m_pulse = 1'b0;
            m_mode = 0; m_col = 0; m_dwell = 0; m_run = 0;
        end else begin
            m_pulse = 1'b0;
            case (m_mode)
                0: begin
                    if (m_dwell == SD - 1) begin
                        m_dwell = 0;
                        if ($countones(~m_s2) == 1) begin
                            for (int i = 0; i < 4; i++)
                                if (!m_s2[i]) m_row = i;
                            m_mode = 1;
                            m_run = 0;
                        end else begin
                            m_col = (m_col + 1) % 4;
                        end
                    end else begin
                        m_dwell++;
                    end
                end
                1: begin
                    if (m_s2 == low_pat(m_row)) begin
                        m_run++;
                        if (m_run == DB) begin
                            m_left = m_right;
                            m_right = KM[m_row*4+m_col];
                            m_pulse = 1'b1;
                            m_mode = 2;
                        end
                    end else begin
                        m_mode = 0;
                        m_dwell = 0;
                        m_col = (m_col + 1) % 4;
                    end
                end
                2: begin
                    if (m_s2 == 4'hF) begin
                        m_mode = 3;
                        m_run = 0;
                    end
                end
                default: begin
                    if (m_s2 == 4'hF) begin
                        m_run++;
                        if (m_run == DB) begin
                            m_mode = 0;
                            m_dwell = 0;
                            m_col = (m_col + 1) % 4;
                        end
                    end else begin
                        m_mode = 2;
                    end
                end
            endcase
            m_s2 = m_s1;
            m_s1 = kp.rows;
        end
    end

    initial forever begin
        @(negedge clk);
        if (cmp_on) begin
            check("cols", kp.cols, low_pat(m_col));
            check("left", kp.left, m_left);
            check("right", kp.right, m_right);
            check("new_key", kp.new_key, m_pulse);
            if (kp.new_key === 1'b1) pulses++;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int p0;
        int changes;
        int k;
        logic [3:0] last;

        repeat (2) @(posedge clk);
        @(negedge clk);
        cmp_on = 1'b1;
        cyc(1);
        reset = 1'b0;
        #1;
        check("rst_cols", kp.cols, 4'b1110);
        check("rst_left", kp.left, 4'h0);
        check("rst_right", kp.right, 4'h0);
        check("rst_new_key", kp.new_key, 1'b0);
        cyc(4);
        check("cols_after_4", kp.cols, 4'b1101);
        cyc(12);
        check("cols_after_16", kp.cols, 4'b1110);

        p0 = pulses;
        down[1*4+1] = 1'b1;
        cyc(60);
        check("k5_pulses", 8'(pulses - p0), 8'd1);
        check("k5_right", kp.right, 4'h5);
        check("k5_left", kp.left, 4'h0);
        down = '0;
        cyc(40);

        p0 = pulses;
        down[0*4+3] = 1'b1;
        cyc(60);
        check("kA_pulses", 8'(pulses - p0), 8'd1);
        check("kA_right", kp.right, 4'hA);
        check("kA_left", kp.left, 4'h5);
        down = '0;
        cyc(40);

        p0 = pulses;
        for (int i = 0; i < 8; i++) begin
            down[0*4+2] = ~down[0*4+2];
            cyc(3);
        end
        down[0*4+2] = 1'b1;
        cyc(60);
        check("bouncy_pulses", 8'(pulses - p0), 8'd1);
        check("bouncy_right", kp.right, 4'h3);
        check("bouncy_left", kp.left, 4'hA);
        down = '0;
        cyc(40);

        p0 = pulses;
        repeat (5) begin
            down[0*4+2] = 1'b1;
            cyc(6);
            down[0*4+2] = 1'b0;
            cyc(3);
        end
        cyc(30);
        check("short_pulses", 8'(pulses - p0), 8'd0);
        check("short_right", kp.right, 4'h3);

        p0 = pulses;
        changes = 0;
        down[1*4+0] = 1'b1;
        down[2*4+0] = 1'b1;
        last = kp.cols;
        repeat (40) begin
            cyc(1);
            if (kp.cols != last) changes++;
            last = kp.cols;
        end
        check("double_pulses", 8'(pulses - p0), 8'd0);
        check("double_rotates", 8'(changes >= 8), 8'd1);
        down = '0;
        cyc(20);

        p0 = pulses;
        down[2*4+1] = 1'b1;
        cyc(50);
        check("k8_pulses", 8'(pulses - p0), 8'd1);
        check("k8_right", kp.right, 4'h8);
        check("k8_left", kp.left, 4'h3);
        down[3*4+3] = 1'b1;
        cyc(30);
        down[3*4+3] = 1'b0;
        down[2*4+1] = 1'b0;
        cyc(5);
        down[2*4+1] = 1'b1;
        cyc(3);
        down[2*4+1] = 1'b0;
        cyc(5);
        down[2*4+1] = 1'b1;
        cyc(3);
        down[2*4+1] = 1'b0;
        cyc(40);
        check("held_pulses", 8'(pulses - p0), 8'd1);
        check("held_right", kp.right, 4'h8);

        p0 = pulses;
        down[1*4+1] = 1'b1;
        k = 0;
        while (!(m_mode == 1 && m_run >= 3) && k < 100) begin
            cyc(1);
            k++;
        end
        check("mid_reached", 8'(k < 100), 8'd1);
        #2;
        reset = 1'b1;
        down = '0;
        #1;
        check("mid_cols", kp.cols, 4'b1110);
        check("mid_left", kp.left, 4'h0);
        check("mid_right", kp.right, 4'h0);
        check("mid_new_key", kp.new_key, 1'b0);
        cyc(2);
        reset = 1'b0;
        cyc(40);
        check("mid_pulses", 8'(pulses - p0), 8'd0);
        check("mid_right_after", kp.right, 4'h0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
